mem_ctrl: RTL and testbench

Sparse-operand buffer and sequencer for one 16x16 activation tile and one 3x3 kernel. It captures activation/weight sparsity flags and data through write ports, then on a start pulse walks the tile row by row, presenting only the non-zero operands to the downstream PE. The PE paces the walk with its row_finish_done_0 and row_cal_done handshake inputs.

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_ctrl_if.sv | 60 ++++++
 rtl/mem_ctrl_prio_enc.sv | 43 ++++
 rtl/mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg: shared sizes, FSM state type and helpers for the sparse-operand
// buffer/sequencer (mem_ctrl) and its priority encoder.
// Optional feature macro used by mem_ctrl: MEM_CTRL_WEI_MASK_EN.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int unsigned DATA_WIDTH      = 8;
    localparam int unsigned IF_WIDTH        = 16;
    localparam int unsigned KERNEL_SIZE     = 9;
    localparam int unsigned ACT_INDEX_WIDTH = 4;
    localparam int unsigned PARALLEL_WIDTH  = KERNEL_SIZE * DATA_WIDTH;

    // Ceiling log2; C_LOG_2(1) = 0.
    function automatic int unsigned C_LOG_2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // One activation row, element 0 in the low byte.
    typedef logic [IF_WIDTH-1:0][DATA_WIDTH-1:0] act_row_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if: write ports, PE handshake and sequencer outputs of mem_ctrl.
//   master : producer/PE side (drives writes, mode/start, handshakes)
//   slave  : mem_ctrl side (drives en, parallel_out, serial_out, indices, flags)
// -----------------------------------------------------------------------------
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                       wr_req_act_flag;
    logic [IF_WIDTH-1:0]        wr_data_act_flag;
    logic                       wr_req_act;
    logic [DATA_WIDTH-1:0]      wr_data_act0,  wr_data_act1,  wr_data_act2,  wr_data_act3;
    logic [DATA_WIDTH-1:0]      wr_data_act4,  wr_data_act5,  wr_data_act6,  wr_data_act7;
    logic [DATA_WIDTH-1:0]      wr_data_act8,  wr_data_act9,  wr_data_act10, wr_data_act11;
    logic [DATA_WIDTH-1:0]      wr_data_act12, wr_data_act13, wr_data_act14, wr_data_act15;
    logic                       wr_req_wei_flag;
    logic [KERNEL_SIZE-1:0]     wr_data_wei_flag;
    logic                       wr_req_wei;
    logic [DATA_WIDTH-1:0]      wr_data_wei;
    logic                       mode;
    logic                       start;
    logic [ACT_INDEX_WIDTH-1:0] cnt;
    logic                       row_finish_done_0;
    logic                       row_finish_done_1;
    logic                       row_cal_done;

    logic                       en;
    logic [PARALLEL_WIDTH-1:0]  parallel_out;
    logic [DATA_WIDTH-1:0]      serial_out;
    logic [ACT_INDEX_WIDTH-1:0] act_index;
    logic [ACT_INDEX_WIDTH-1:0] wei_index;
    logic [ACT_INDEX_WIDTH-1:0] row_index;
    logic [ACT_INDEX_WIDTH-1:0] row_val_num;
    logic                       zero_flag;

    modport master (
        output wr_req_act_flag, wr_data_act_flag, wr_req_act,
               wr_data_act0,  wr_data_act1,  wr_data_act2,  wr_data_act3,
               wr_data_act4,  wr_data_act5,  wr_data_act6,  wr_data_act7,
               wr_data_act8,  wr_data_act9,  wr_data_act10, wr_data_act11,
               wr_data_act12, wr_data_act13, wr_data_act14, wr_data_act15,
               wr_req_wei_flag, wr_data_wei_flag, wr_req_wei, wr_data_wei,
               mode, start, cnt, row_finish_done_0, row_finish_done_1, row_cal_done,
        input  en, parallel_out, serial_out, act_index, wei_index, row_index,
               row_val_num, zero_flag
    );

    modport slave (
        input  wr_req_act_flag, wr_data_act_flag, wr_req_act,
               wr_data_act0,  wr_data_act1,  wr_data_act2,  wr_data_act3,
               wr_data_act4,  wr_data_act5,  wr_data_act6,  wr_data_act7,
               wr_data_act8,  wr_data_act9,  wr_data_act10, wr_data_act11,
               wr_data_act12, wr_data_act13, wr_data_act14, wr_data_act15,
               wr_req_wei_flag, wr_data_wei_flag, wr_req_wei, wr_data_wei,
               mode, start, cnt, row_finish_done_0, row_finish_done_1, row_cal_done,
        output en, parallel_out, serial_out, act_index, wei_index, row_index,
               row_val_num, zero_flag
    );

endinterface

// File: rtl/mem_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// mem_ctrl_prio_enc: combinational search for the lowest set flag bit at or
// above start_i, plus the popcount of the whole flag vector.
//   flags_i : flag vector
//   start_i : first bit position eligible (may equal WIDTH -> nothing found)
//   idx_c   : position of the found bit (0 when none)
//   valid_c : a set bit was found
//   count_c : number of set bits in flags_i
// -----------------------------------------------------------------------------
module mem_ctrl_prio_enc
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IDX_WIDTH = C_LOG_2(WIDTH),
    parameter int unsigned CNT_WIDTH = C_LOG_2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     flags_i,
    input  logic [IDX_WIDTH:0]   start_i,
    output logic [IDX_WIDTH-1:0] idx_c,
    output logic                 valid_c,
    output logic [CNT_WIDTH-1:0] count_c
);

    // Descending scan so the last match written is the lowest eligible bit.
    always_comb begin : find_next
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (flags_i[i] && (i >= int'(start_i))) begin
                idx_c   = IDX_WIDTH'(i);
                valid_c = 1'b1;
            end
        end
    end

    always_comb begin : popcount
        count_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_c = count_c + CNT_WIDTH'(flags_i[i]);
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl: sparse-operand buffer and sequencer for one 16x16 activation tile
// and one 3x3 kernel. Write ports fill flag/data memories at any time; a start
// pulse walks the tile row by row presenting only non-zero operands to the PE,
// paced by row_finish_done_0 / row_cal_done.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : mem_ctrl_if.slave (writes, mode/start, PE handshake, outputs)
// Optional: define MEM_CTRL_WEI_MASK_EN to zero parallel_out bytes whose
// weight-flag bit is clear; otherwise parallel_out is raw weight memory.
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    mem_ctrl_if.slave bus
);

    localparam int unsigned IDX_W  = ACT_INDEX_WIDTH;
    localparam int unsigned ROW_W  = C_LOG_2(IF_WIDTH);
    localparam int unsigned WPTR_W = C_LOG_2(KERNEL_SIZE);
    localparam int unsigned APOP_W = C_LOG_2(IF_WIDTH + 1);
    localparam int unsigned WPOP_W = C_LOG_2(KERNEL_SIZE + 1);

    // Storage
    logic [IF_WIDTH-1:0]    flag_mem_q [IF_WIDTH];
    logic [IF_WIDTH-1:0]    flag_mem_d [IF_WIDTH];
    act_row_t               act_mem_q  [IF_WIDTH];
    act_row_t               act_mem_d  [IF_WIDTH];
    logic [DATA_WIDTH-1:0]  wei_mem_q  [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]  wei_mem_d  [KERNEL_SIZE];
    logic [KERNEL_SIZE-1:0] wei_flag_q, wei_flag_d;
    logic [ROW_W-1:0]       ptr_f_q, ptr_f_d;
    logic [ROW_W-1:0]       ptr_a_q, ptr_a_d;
    logic [WPTR_W-1:0]      ptr_w_q, ptr_w_d;

    // Sequencer
    state_e                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   mode_q, mode_d;
    logic                   en_q, en_d;
    logic [DATA_WIDTH-1:0]  serial_out_q, serial_out_d;
    logic [IDX_W-1:0]       act_index_q, act_index_d;
    logic [IDX_W-1:0]       wei_index_q, wei_index_d;
    logic [IDX_W-1:0]       row_index_q, row_index_d;
    logic [IDX_W-1:0]       row_val_num_q, row_val_num_d;
    logic                   zero_flag_q, zero_flag_d;
    logic                   row_done_c;

    act_row_t               wr_act_row_c;
    logic [IDX_W:0]         act_start_c, wei_start_c;
    logic [IDX_W-1:0]       act_idx_c, wei_idx_c;
    logic                   act_vld_c, wei_vld_c;
    logic [APOP_W-1:0]      act_pop_c;
    logic [WPOP_W-1:0]      wei_pop_unused;
    logic [PARALLEL_WIDTH-1:0] parallel_out_c;
    logic                   unused_inputs;

    assign unused_inputs = ^{bus.cnt, bus.row_finish_done_1};

    assign wr_act_row_c = {bus.wr_data_act15, bus.wr_data_act14, bus.wr_data_act13,
                           bus.wr_data_act12, bus.wr_data_act11, bus.wr_data_act10,
                           bus.wr_data_act9,  bus.wr_data_act8,  bus.wr_data_act7,
                           bus.wr_data_act6,  bus.wr_data_act5,  bus.wr_data_act4,
                           bus.wr_data_act3,  bus.wr_data_act2,  bus.wr_data_act1,
                           bus.wr_data_act0};

    // Write path: pointers advance while a request is held, restart at 0 when it drops.
    always_comb begin : wr_path
        flag_mem_d = flag_mem_q;
        act_mem_d  = act_mem_q;
        wei_mem_d  = wei_mem_q;
        wei_flag_d = wei_flag_q;
        ptr_f_d    = '0;
        ptr_a_d    = '0;
        ptr_w_d    = '0;
        if (bus.wr_req_act_flag) begin
            flag_mem_d[ptr_f_q] = bus.wr_data_act_flag;
            ptr_f_d             = ptr_f_q + ROW_W'(1);
        end
        if (bus.wr_req_act) begin
            act_mem_d[ptr_a_q] = wr_act_row_c;
            ptr_a_d            = ptr_a_q + ROW_W'(1);
        end
        if (bus.wr_req_wei_flag) begin
            wei_flag_d = bus.wr_data_wei_flag;
        end
        if (bus.wr_req_wei) begin
            wei_mem_d[ptr_w_q] = bus.wr_data_wei;
            ptr_w_d = (ptr_w_q == WPTR_W'(KERNEL_SIZE - 1)) ? '0 : ptr_w_q + WPTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin : wr_regs
        if (!reset) begin
            for (int i = 0; i < IF_WIDTH; i++) begin
                flag_mem_q[i] <= '0;
                act_mem_q[i]  <= '0;
            end
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                wei_mem_q[k] <= '0;
            end
            wei_flag_q <= '0;
            ptr_f_q    <= '0;
            ptr_a_q    <= '0;
            ptr_w_q    <= '0;
        end else begin
            flag_mem_q <= flag_mem_d;
            act_mem_q  <= act_mem_d;
            wei_mem_q  <= wei_mem_d;
            wei_flag_q <= wei_flag_d;
            ptr_f_q    <= ptr_f_d;
            ptr_a_q    <= ptr_a_d;
            ptr_w_q    <= ptr_w_d;
        end
    end

    // Weight bytes packed low-to-high; optionally masked by the weight flags.
    always_comb begin : par_out
        parallel_out_c = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
`ifdef MEM_CTRL_WEI_MASK_EN
            parallel_out_c[k*DATA_WIDTH +: DATA_WIDTH] = wei_flag_q[k] ? wei_mem_q[k] : '0;
`else
            parallel_out_c[k*DATA_WIDTH +: DATA_WIDTH] = wei_mem_q[k];
`endif
        end
    end

    // SCAN searches from bit 0; RUN searches past the current index.
    always_comb begin : search_start
        act_start_c = '0;
        wei_start_c = '0;
        if (state_q == ST_RUN) begin
            act_start_c = (IDX_W + 1)'(act_index_q) + (IDX_W + 1)'(1);
            if (!bus.row_cal_done) begin
                wei_start_c = (IDX_W + 1)'(wei_index_q) + (IDX_W + 1)'(1);
            end
        end
    end

    mem_ctrl_prio_enc #(
        .WIDTH     (IF_WIDTH),
        .IDX_WIDTH (IDX_W),
        .CNT_WIDTH (APOP_W)
    ) u_act_enc (
        .flags_i (flag_mem_q[row_q]),
        .start_i (act_start_c),
        .idx_c   (act_idx_c),
        .valid_c (act_vld_c),
        .count_c (act_pop_c)
    );

    mem_ctrl_prio_enc #(
        .WIDTH     (KERNEL_SIZE),
        .IDX_WIDTH (IDX_W),
        .CNT_WIDTH (WPOP_W)
    ) u_wei_enc (
        .flags_i (wei_flag_q),
        .start_i (wei_start_c),
        .idx_c   (wei_idx_c),
        .valid_c (wei_vld_c),
        .count_c (wei_pop_unused)
    );

    // Sequencer next-state and registered-output logic.
    always_comb begin : fsm_next
        state_d       = state_q;
        row_d         = row_q;
        mode_d        = mode_q;
        en_d          = en_q;
        serial_out_d  = serial_out_q;
        act_index_d   = act_index_q;
        wei_index_d   = wei_index_q;
        row_index_d   = row_index_q;
        row_val_num_d = row_val_num_q;
        zero_flag_d   = zero_flag_q;
        row_done_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    row_d   = '0;
                    mode_d  = bus.mode;
                    en_d    = 1'b1;
                end
            end

            ST_SCAN: begin
                row_index_d   = IDX_W'(row_q);
                row_val_num_d = IDX_W'(act_pop_c);
                serial_out_d  = act_vld_c ? act_mem_q[row_q][act_idx_c] : '0;
                act_index_d   = act_vld_c ? act_idx_c : '0;
                wei_index_d   = wei_vld_c ? wei_idx_c : '0;
                zero_flag_d   = !act_vld_c || (mode_q && !wei_vld_c);
                state_d       = ST_RUN;
            end

            ST_RUN: begin
                if (bus.row_cal_done) begin
                    // Mode 1 moves to the next activation; otherwise the row is finished.
                    if (mode_q && act_vld_c) begin
                        serial_out_d = act_mem_q[row_q][act_idx_c];
                        act_index_d  = act_idx_c;
                        wei_index_d  = wei_vld_c ? wei_idx_c : '0;
                    end else begin
                        row_done_c = 1'b1;
                    end
                end else if (!mode_q) begin
                    if (act_vld_c) begin
                        serial_out_d = act_mem_q[row_q][act_idx_c];
                        act_index_d  = act_idx_c;
                    end
                end else if (bus.row_finish_done_0 && !zero_flag_q && wei_vld_c) begin
                    wei_index_d = wei_idx_c;
                end

                if (row_done_c) begin
                    if (row_q == ROW_W'(IF_WIDTH - 1)) begin
                        state_d     = ST_IDLE;
                        row_d       = '0;
                        en_d        = 1'b0;
                        row_index_d = '0;
                    end else begin
                        state_d = ST_SCAN;
                        row_d   = row_q + ROW_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin : fsm_regs
        if (!reset) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            mode_q        <= 1'b0;
            en_q          <= 1'b0;
            serial_out_q  <= '0;
            act_index_q   <= '0;
            wei_index_q   <= '0;
            row_index_q   <= '0;
            row_val_num_q <= '0;
            zero_flag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            mode_q        <= mode_d;
            en_q          <= en_d;
            serial_out_q  <= serial_out_d;
            act_index_q   <= act_index_d;
            wei_index_q   <= wei_index_d;
            row_index_q   <= row_index_d;
            row_val_num_q <= row_val_num_d;
            zero_flag_q   <= zero_flag_d;
        end
    end

    assign bus.en           = en_q;
    assign bus.parallel_out = parallel_out_c;
    assign bus.serial_out   = serial_out_q;
    assign bus.act_index    = act_index_q;
    assign bus.wei_index    = wei_index_q;
    assign bus.row_index    = row_index_q;
    assign bus.row_val_num  = row_val_num_q;
    assign bus.zero_flag    = zero_flag_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl: self-checking bench for mem_ctrl. Keeps a plain array model of
// the flag/activation/weight memories and derives the expected walk (set-bit
// lists, popcounts, weight stepping) directly from it.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] m_flag [16];
    logic [7:0]  m_act  [16][16];
    logic [8:0]  m_wflag;
    logic [7:0]  m_wei  [9];

    task automatic drive_idle();
        bus.wr_req_act_flag = 1'b0; bus.wr_data_act_flag = '0;
        bus.wr_req_act = 1'b0;
        bus.wr_data_act0 = '0;  bus.wr_data_act1 = '0;  bus.wr_data_act2 = '0;  bus.wr_data_act3 = '0;
        bus.wr_data_act4 = '0;  bus.wr_data_act5 = '0;  bus.wr_data_act6 = '0;  bus.wr_data_act7 = '0;
        bus.wr_data_act8 = '0;  bus.wr_data_act9 = '0;  bus.wr_data_act10 = '0; bus.wr_data_act11 = '0;
        bus.wr_data_act12 = '0; bus.wr_data_act13 = '0; bus.wr_data_act14 = '0; bus.wr_data_act15 = '0;
        bus.wr_req_wei_flag = 1'b0; bus.wr_data_wei_flag = '0;
        bus.wr_req_wei = 1'b0; bus.wr_data_wei = '0;
        bus.mode = 1'b0; bus.start = 1'b0; bus.cnt = '0;
        bus.row_finish_done_0 = 1'b0; bus.row_finish_done_1 = 1'b0; bus.row_cal_done = 1'b0;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 16; r++) begin
            m_flag[r] = '0;
            for (int c = 0; c < 16; c++) m_act[r][c] = '0;
        end
        m_wflag = '0;
        for (int k = 0; k < 9; k++) m_wei[k] = '0;
    endtask

    function automatic logic [71:0] exp_par();
        logic [71:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) begin
`ifdef MEM_CTRL_WEI_MASK_EN
            if (m_wflag[k]) v[k*8 +: 8] = m_wei[k];
`else
            v[k*8 +: 8] = m_wei[k];
`endif
        end
        return v;
    endfunction

    task automatic drive_act_row(input int r);
        bus.wr_data_act0  = m_act[r][0];  bus.wr_data_act1  = m_act[r][1];
        bus.wr_data_act2  = m_act[r][2];  bus.wr_data_act3  = m_act[r][3];
        bus.wr_data_act4  = m_act[r][4];  bus.wr_data_act5  = m_act[r][5];
        bus.wr_data_act6  = m_act[r][6];  bus.wr_data_act7  = m_act[r][7];
        bus.wr_data_act8  = m_act[r][8];  bus.wr_data_act9  = m_act[r][9];
        bus.wr_data_act10 = m_act[r][10]; bus.wr_data_act11 = m_act[r][11];
        bus.wr_data_act12 = m_act[r][12]; bus.wr_data_act13 = m_act[r][13];
        bus.wr_data_act14 = m_act[r][14]; bus.wr_data_act15 = m_act[r][15];
    endtask

    // Random tile; higher density thins the flags out; some rows forced empty.
    task automatic gen_tile(input int density);
        logic [31:0] f;
        for (int r = 0; r < 16; r++) begin
            f = $urandom;
            for (int d = 0; d < density; d++) f = f & $urandom;
            m_flag[r] = ($urandom_range(0, 5) == 0) ? 16'h0000 : f[15:0];
            for (int c = 0; c < 16; c++) m_act[r][c] = 8'($urandom);
        end
    endtask

    task automatic load_tile();
        for (int r = 0; r < 16; r++) begin
            bus.wr_req_act_flag  = 1'b1;
            bus.wr_data_act_flag = m_flag[r];
            bus.wr_req_act       = 1'b1;
            drive_act_row(r);
            @(negedge clk);
        end
        bus.wr_req_act_flag = 1'b0;
        bus.wr_req_act      = 1'b0;
    endtask

    task automatic load_weights();
        bus.wr_req_wei_flag  = 1'b1;
        bus.wr_data_wei_flag = m_wflag;
        for (int k = 0; k < 9; k++) begin
            bus.wr_req_wei  = 1'b1;
            bus.wr_data_wei = m_wei[k];
            @(negedge clk);
            bus.wr_req_wei_flag = 1'b0;
        end
        bus.wr_req_wei = 1'b0;
    endtask

    // Full 16-row walk checked against the model. Entered and left at a negedge.
    task automatic run_walk(input logic m, input bit disturb);
        int q[$];
        int wq[$];
        logic [15:0] nf;
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = ~m;
        checks++; if (bus.en !== 1'b1) begin errors++; $display("FAIL walk_en_on: got %b expected 1", bus.en); end
        wq = {};
        for (int k = 0; k < 9; k++) if (m_wflag[k]) wq.push_back(k);
        for (int r = 0; r < 16; r++) begin
            q = {};
            for (int c = 0; c < 16; c++) if (m_flag[r][c]) q.push_back(c);
            @(negedge clk);
            if (disturb && r == 3) begin
                bus.start = 1'b0; bus.mode = ~m;
                bus.wr_req_act_flag = 1'b0; bus.wr_req_wei = 1'b0; bus.wr_req_wei_flag = 1'b0;
            end
            checks++; if (bus.en !== 1'b1) begin errors++; $display("FAIL en_busy r=%0d: got %b expected 1", r, bus.en); end
            checks++; if (bus.row_index !== 4'(r)) begin errors++; $display("FAIL row_index: got %0d expected %0d", bus.row_index, r); end
            checks++; if (bus.row_val_num !== 4'(q.size())) begin errors++; $display("FAIL row_val_num r=%0d: got %0d expected %0d", r, bus.row_val_num, 4'(q.size())); end
            checks++; if (bus.zero_flag !== ((q.size() == 0) || (m && wq.size() == 0))) begin errors++; $display("FAIL zero_flag r=%0d: got %b", r, bus.zero_flag); end
            if (q.size() == 0) begin
                checks++; if (bus.serial_out !== 8'h00) begin errors++; $display("FAIL empty_serial r=%0d: got %0h expected 0", r, bus.serial_out); end
            end
            if (!m) begin
                for (int k = 0; k < q.size(); k++) begin
                    if (k > 0) @(negedge clk);
                    checks++; if (bus.act_index !== 4'(q[k])) begin errors++; $display("FAIL m0_act_index r=%0d k=%0d: got %0d expected %0d", r, k, bus.act_index, q[k]); end
                    checks++; if (bus.serial_out !== m_act[r][q[k]]) begin errors++; $display("FAIL m0_serial r=%0d k=%0d: got %0h expected %0h", r, k, bus.serial_out, m_act[r][q[k]]); end
                end
                repeat ($urandom_range(1, 2)) begin
                    @(negedge clk);
                    if (q.size() > 0) begin
                        checks++; if (bus.act_index !== 4'(q[q.size()-1])) begin errors++; $display("FAIL m0_hold r=%0d: got %0d expected %0d", r, bus.act_index, q[q.size()-1]); end
                    end
                end
            end else begin
                for (int a = 0; a < q.size(); a++) begin
                    checks++; if (bus.act_index !== 4'(q[a])) begin errors++; $display("FAIL m1_act_index r=%0d: got %0d expected %0d", r, bus.act_index, q[a]); end
                    checks++; if (bus.serial_out !== m_act[r][q[a]]) begin errors++; $display("FAIL m1_serial r=%0d: got %0h expected %0h", r, bus.serial_out, m_act[r][q[a]]); end
                    if (wq.size() > 0) begin
                        checks++; if (bus.wei_index !== 4'(wq[0])) begin errors++; $display("FAIL wei_first r=%0d: got %0d expected %0d", r, bus.wei_index, wq[0]); end
                    end
                    for (int j = 1; j < wq.size(); j++) begin
                        bus.row_finish_done_0 = 1'b1;
                        @(negedge clk);
                        bus.row_finish_done_0 = 1'b0;
                        checks++; if (bus.wei_index !== 4'(wq[j])) begin errors++; $display("FAIL wei_step r=%0d j=%0d: got %0d expected %0d", r, j, bus.wei_index, wq[j]); end
                    end
                    bus.row_finish_done_0 = 1'b1;
                    @(negedge clk);
                    bus.row_finish_done_0 = 1'b0;
                    checks++; if (bus.act_index !== 4'(q[a])) begin errors++; $display("FAIL finish_no_act r=%0d: got %0d expected %0d", r, bus.act_index, q[a]); end
                    if (wq.size() > 0) begin
                        checks++; if (bus.wei_index !== 4'(wq[wq.size()-1])) begin errors++; $display("FAIL wei_hold r=%0d: got %0d expected %0d", r, bus.wei_index, wq[wq.size()-1]); end
                    end
                    if (a != q.size() - 1) begin
                        bus.row_cal_done      = 1'b1;
                        bus.row_finish_done_0 = 1'($urandom);
                        @(negedge clk);
                        bus.row_cal_done      = 1'b0;
                        bus.row_finish_done_0 = 1'b0;
                    end
                end
            end
            bus.row_cal_done = 1'b1;
            @(negedge clk);
            bus.row_cal_done = 1'b0;
            if (disturb && r == 2) begin
                nf = 16'($urandom);
                bus.start = 1'b1; bus.mode = ~m;
                bus.wr_req_act_flag = 1'b1; bus.wr_data_act_flag = nf;
                bus.wr_req_wei = 1'b1; bus.wr_data_wei = 8'($urandom);
                bus.wr_req_wei_flag = 1'b1; bus.wr_data_wei_flag = 9'($urandom);
                m_flag[0] = nf;
                m_wei[0]  = bus.wr_data_wei;
                m_wflag   = bus.wr_data_wei_flag;
            end
        end
        checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL walk_en_off: got %b expected 0", bus.en); end
        checks++; if (bus.row_index !== 4'd0) begin errors++; $display("FAIL walk_row_index_end: got %0d expected 0", bus.row_index); end
        @(negedge clk);
        checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL idle_stays: got %b expected 0", bus.en); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        model_clear();
        repeat (2) @(negedge clk);
        checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus.en); end
        checks++; if (bus.parallel_out !== 72'h0) begin errors++; $display("FAIL reset_par: got %0h expected 0", bus.parallel_out); end
        checks++; if ({bus.serial_out, bus.act_index, bus.wei_index, bus.row_index, bus.row_val_num, bus.zero_flag} !== '0) begin
            errors++; $display("FAIL reset_outputs: got serial=%0h act=%0d wei=%0d row=%0d num=%0d zf=%b expected all 0",
                bus.serial_out, bus.act_index, bus.wei_index, bus.row_index, bus.row_val_num, bus.zero_flag);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        gen_tile(2);
        m_flag[0]  = 16'b0000_0011_1111_1111;
        for (int c = 0; c < 16; c++) m_act[0][c] = 8'(c);
        m_flag[7]  = 16'h0000;
        m_flag[15] = 16'hFFFF;
        load_tile();
        run_walk(1'b0, 1'b0);
    endtask

    task automatic test_mode1();
        logic [71:0] exp;
        m_wflag = 9'b1_0001_0001;
        for (int k = 0; k < 9; k++) m_wei[k] = 8'(k + 1);
        load_weights();
`ifdef MEM_CTRL_WEI_MASK_EN
        exp = 72'h09_00_00_00_05_00_00_00_01;
`else
        exp = 72'h09_08_07_06_05_04_03_02_01;
`endif
        checks++; if (bus.parallel_out !== exp) begin errors++; $display("FAIL par_directed: got %0h expected %0h", bus.parallel_out, exp); end
        gen_tile(3);
        load_tile();
        run_walk(1'b1, 1'b0);
    endtask

    task automatic test_zero_kernel();
        m_wflag = '0;
        load_weights();
        checks++; if (bus.parallel_out !== exp_par()) begin errors++; $display("FAIL par_zero_kernel: got %0h expected %0h", bus.parallel_out, exp_par()); end
        gen_tile(3);
        load_tile();
        run_walk(1'b1, 1'b0);
    endtask

    task automatic test_writes_during_walk();
        m_wflag = 9'($urandom);
        for (int k = 0; k < 9; k++) m_wei[k] = 8'($urandom);
        load_weights();
        gen_tile(2);
        load_tile();
        run_walk(1'b0, 1'b1);
        checks++; if (bus.parallel_out !== exp_par()) begin errors++; $display("FAIL par_after_walk_write: got %0h expected %0h", bus.parallel_out, exp_par()); end
    endtask

    task automatic test_back_to_back();
        run_walk(1'b0, 1'b0);
        run_walk(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_walk();
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat ($urandom_range(5, 30)) begin
            bus.row_cal_done = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        bus.row_cal_done = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL midreset_en: got %b expected 0", bus.en); end
        checks++; if (bus.row_index !== 4'd0) begin errors++; $display("FAIL midreset_row: got %0d expected 0", bus.row_index); end
        checks++; if ({bus.serial_out, bus.act_index, bus.wei_index, bus.row_val_num, bus.zero_flag} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got serial=%0h act=%0d wei=%0d num=%0d zf=%b expected all 0",
                bus.serial_out, bus.act_index, bus.wei_index, bus.row_val_num, bus.zero_flag);
        end
        checks++; if (bus.parallel_out !== 72'h0) begin errors++; $display("FAIL midreset_par: got %0h expected 0", bus.parallel_out); end
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        run_walk(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_zero_kernel();
        test_writes_during_walk();
        test_back_to_back();
        test_reset_mid_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
